// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result bundle between ALU control and the multi-cycle shift sequencer
interface shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic             s3;
    logic             s2;
    logic [CNT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] reg_out;
    logic             carry_out;
    modport master (output start, A, s3, s2, amount, input busy, done, reg_out, carry_out);
    modport slave (input start, A, s3, s2, amount, output busy, done, reg_out, carry_out);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: applies a latched 1-bit shift/rotate op once per clock for a captured step count
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst,
    shift_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic [WIDTH-1:0] r, step_r;
    logic             c, step_c;
    // op[1] selects left, op[0] selects zero fill instead of wrap-around
    always_comb begin
        step_r = op[1] ? {r[WIDTH-2:0], op[0] ? 1'b0 : r[WIDTH-1]}
                       : {op[0] ? 1'b0 : r[0], r[WIDTH-1:1]};
        step_c = op[1] ? r[WIDTH-1] : r[0];
        nxt = state == IDLE  ? (bus.start ? (bus.amount == '0 ? DONE : SHIFT) : IDLE)
            : state == SHIFT ? (cnt == CNT_W'(1) ? DONE : SHIFT)
            : IDLE;
        bus.busy = state == SHIFT;
        bus.done = state == DONE;
        bus.reg_out = r;
        bus.carry_out = c;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op <= '0;
            r <= '0;
            c <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                r <= bus.A;
                op <= {bus.s3, bus.s2};
                cnt <= bus.amount;
                c <= 1'b0;
            end else if (state == SHIFT) begin
                r <= step_r;
                c <= step_c;
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq, checking result, carry, latency and busy length
module tb_shift_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   bcnt = 0;
    typedef struct {
        logic [7:0] r;
        logic       c;
        int         cyc;
        int         n;
    } exp_t;
    exp_t sb[$];
    shift_seq_if #(.WIDTH(8)) bus ();
    shift_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [7:0] a, input logic [1:0] op, input int n);
        exp_t e;
        e.r = a;
        e.c = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (op[1]) begin
                e.c = e.r[7];
                e.r = op[0] ? {e.r[6:0], 1'b0} : {e.r[6:0], e.r[7]};
            end else begin
                e.c = e.r[0];
                e.r = op[0] ? {1'b0, e.r[7:1]} : {e.r[0], e.r[7:1]};
            end
        end
        e.n = n;
        return e;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (rst) bcnt = 0;
        else begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                if (sb.size() == 0) check("spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("reg_out", {24'd0, bus.reg_out}, {24'd0, e.r});
                    check("carry_out", {31'd0, bus.carry_out}, {31'd0, e.c});
                    check("latency", cyc, e.cyc);
                    check("busy_cycles", bcnt, e.n);
                end
                bcnt = 0;
            end
        end
    end
    task automatic run_op(input logic [7:0] a, input logic [1:0] op, input int n);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        {bus.s3, bus.s2} = op;
        bus.amount = 3'(n);
        @(posedge clk);
        #1;
        e = model(a, op, n);
        e.cyc = cyc + n;
        sb.push_back(e);
        check("accepted", {31'd0, bus.busy | bus.done}, 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom;
        bus.amount = 3'($urandom);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask
    initial begin
        bus.start = 1'b1;
        bus.A = 8'hAA;
        bus.s3 = 1'b1;
        bus.s2 = 1'b1;
        bus.amount = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reg_out", {24'd0, bus.reg_out}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_carry", {31'd0, bus.carry_out}, 0);
        rst = 1'b0;
        bus.start = 1'b0;
        run_op(8'b1001_0110, 2'b11, 3);
        wait_idle();
        check("hold_reg_out", {24'd0, bus.reg_out}, 32'hB0);
        run_op(8'h81, 2'b00, 1);
        wait_idle();
        run_op(8'h81, 2'b10, 7);
        wait_idle();
        run_op(8'hFF, 2'b01, 0);
        wait_idle();
        run_op(8'h3C, 2'b10, 5);
        bus.start = 1'b1;
        bus.A = 8'h00;
        bus.amount = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        run_op(8'hC3, 2'b01, 2);
        wait_idle();
        run_op(8'h5A, 2'b11, 5);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_reg_out", {24'd0, bus.reg_out}, 0);
        check("midrst_busy", {31'd0, bus.busy}, 0);
        check("midrst_done", {31'd0, bus.done}, 0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            run_op(8'($urandom), 2'($urandom), $urandom_range(0, 7));
            wait_idle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
